// File: rtl/alu_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu_arbiter_if                                          |
// | Brief    : Requester, shared-ALU and response signals of the       |
// |            two-port ALU arbiter, grouped with master/slave views.  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface alu_arbiter_if #(
  parameter int DW   = 32,
  parameter int CW   = 4,
  parameter int CNTW = 16
) ();
  // Requester 0
  logic            req0_valid_i;
  logic            req0_ready_o;
  logic [DW-1:0]   req0_src1_i;
  logic [DW-1:0]   req0_src2_i;
  logic [CW-1:0]   req0_ctrl_i;
  // Requester 1
  logic            req1_valid_i;
  logic            req1_ready_o;
  logic [DW-1:0]   req1_src1_i;
  logic [DW-1:0]   req1_src2_i;
  logic [CW-1:0]   req1_ctrl_i;
  // Shared ALU
  logic [DW-1:0]   alu_src1_o;
  logic [DW-1:0]   alu_src2_o;
  logic [CW-1:0]   alu_ctrl_o;
  logic [DW-1:0]   alu_result_i;
  logic            alu_zero_i;
  // Response
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic            rsp_id_o;
  logic [DW-1:0]   rsp_result_o;
  logic            rsp_zero_o;
  logic            rsp_err_o;
  logic [CNTW-1:0] ops_cnt_o;

  // Arbiter side
  modport slave (
    input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    input  alu_result_i, alu_zero_i, rsp_ready_i,
    output req0_ready_o, req1_ready_o,
    output alu_src1_o, alu_src2_o, alu_ctrl_o,
    output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o, ops_cnt_o
  );

  // Requester / ALU / consumer side
  modport master (
    output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    output alu_result_i, alu_zero_i, rsp_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  alu_src1_o, alu_src2_o, alu_ctrl_o,
    input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o, ops_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu_arbiter                                             |
// | Brief    : Round-robin sharing of one combinational ALU between    |
// |            two requesters, registered valid/ready response and     |
// |            screening of unsupported control codes.                 |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module alu_arbiter #(
  parameter int DW   = 32,
  parameter int CW   = 4,
  parameter int CNTW = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_arbiter_if.slave bus
);

  localparam logic [CW-1:0] c_ctrl_and = CW'(4'b0000);
  localparam logic [CW-1:0] c_ctrl_or  = CW'(4'b0001);
  localparam logic [CW-1:0] c_ctrl_add = CW'(4'b0010);
  localparam logic [CW-1:0] c_ctrl_sub = CW'(4'b0110);
  localparam logic [CW-1:0] c_ctrl_slt = CW'(4'b0111);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_prio;
  logic [CNTW-1:0] r_ops_cnt;
  logic            r_rsp_id;
  logic [DW-1:0]   r_rsp_result;
  logic            r_rsp_zero;
  logic            r_rsp_err;

  logic            w_winner;
  logic            w_accept;
  logic            w_legal;
  logic [DW-1:0]   w_src1;
  logic [DW-1:0]   w_src2;
  logic [CW-1:0]   w_ctrl;

  // Pick the winner (priority only matters on a tie) and steer its operands.
  always_comb begin
    w_winner = bus.req1_valid_i;
    if (bus.req0_valid_i && bus.req1_valid_i) begin
      w_winner = r_prio;
    end
    w_src1 = w_winner ? bus.req1_src1_i : bus.req0_src1_i;
    w_src2 = w_winner ? bus.req1_src2_i : bus.req0_src2_i;
    w_ctrl = w_winner ? bus.req1_ctrl_i : bus.req0_ctrl_i;
  end

  // Only the five ALU operations are supported; everything else is flagged.
  always_comb begin
    w_legal = (w_ctrl == c_ctrl_and) || (w_ctrl == c_ctrl_or)  ||
              (w_ctrl == c_ctrl_add) || (w_ctrl == c_ctrl_sub) ||
              (w_ctrl == c_ctrl_slt);
  end

  // Next-state, ready generation and ALU drive; ALU sees idle values unless granting.
  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    bus.req0_ready_o = 1'b0;
    bus.req1_ready_o = 1'b0;
    bus.alu_src1_o   = '0;
    bus.alu_src2_o   = '0;
    bus.alu_ctrl_o   = c_ctrl_add;
    case (r_state)
      IDLE: begin
        // Readies stay low while reset is held even though the state is IDLE.
        if (rst_i && (bus.req0_valid_i || bus.req1_valid_i)) begin
          w_accept         = 1'b1;
          bus.req0_ready_o = ~w_winner;
          bus.req1_ready_o = w_winner;
          bus.alu_src1_o   = w_src1;
          bus.alu_src2_o   = w_src2;
          bus.alu_ctrl_o   = w_legal ? w_ctrl : c_ctrl_add;
          w_state_nxt      = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the response and advance priority and counter on every grant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_prio       <= 1'b0;
      r_ops_cnt    <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else if (w_accept) begin
      r_prio       <= ~w_winner;
      r_ops_cnt    <= r_ops_cnt + CNTW'(1);
      r_rsp_id     <= w_winner;
      r_rsp_result <= w_legal ? bus.alu_result_i : '0;
      r_rsp_zero   <= w_legal ? bus.alu_zero_i : 1'b0;
      r_rsp_err    <= ~w_legal;
    end
  end

  assign bus.rsp_valid_o  = (r_state == RESP);
  assign bus.rsp_id_o     = r_rsp_id;
  assign bus.rsp_result_o = r_rsp_result;
  assign bus.rsp_zero_o   = r_rsp_zero;
  assign bus.rsp_err_o    = r_rsp_err;
  assign bus.ops_cnt_o    = r_ops_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_alu_arbiter                                          |
// | Brief    : Scoreboard bench for alu_arbiter with a behavioural     |
// |            ALU and a reference model of the arbitration rules.     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_alu_arbiter;
  localparam int DW   = 32;
  localparam int CW   = 4;
  // Narrow counter so the wrap from all-ones to zero is reachable quickly.
  localparam int CNTW = 10;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  typedef struct {
    logic            id;
    logic [DW-1:0]   res;
    logic            zero;
    logic            err;
    logic [CNTW-1:0] cnt;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  // Reference-model state: response outstanding, tie priority, accepted ops.
  logic        m_busy = 1'b0;
  logic        m_prio = 1'b0;
  int unsigned m_cnt  = 0;

  always #5 clk_i = ~clk_i;

  alu_arbiter_if #(.DW(DW), .CW(CW), .CNTW(CNTW)) bus ();

  alu_arbiter #(.DW(DW), .CW(CW), .CNTW(CNTW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Stand-in for the existing ALU; unsupported codes give a recognisable junk value.
  always_comb begin
    case (bus.alu_ctrl_o)
      4'b0000: bus.alu_result_i = bus.alu_src1_o & bus.alu_src2_o;
      4'b0001: bus.alu_result_i = bus.alu_src1_o | bus.alu_src2_o;
      4'b0010: bus.alu_result_i = bus.alu_src1_o + bus.alu_src2_o;
      4'b0110: bus.alu_result_i = bus.alu_src1_o - bus.alu_src2_o;
      4'b0111: bus.alu_result_i = ($signed(bus.alu_src1_o) < $signed(bus.alu_src2_o)) ? 32'd1 : 32'd0;
      default: bus.alu_result_i = 32'hDEAD_BEEF;
    endcase
  end
  assign bus.alu_zero_i = (bus.alu_result_i == '0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk_op(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_t o;
    o.ctrl = c;
    o.a    = a;
    o.b    = b;
    return o;
  endfunction

  // Expected response of one operation, straight from the operation table.
  function automatic exp_t ref_rsp(input logic id, input op_t op, input int unsigned cnt);
    exp_t e;
    e.id  = id;
    e.err = 1'b0;
    e.cnt = CNTW'(cnt);
    case (op.ctrl)
      4'b0000: e.res = op.a & op.b;
      4'b0001: e.res = op.a | op.b;
      4'b0010: e.res = op.a + op.b;
      4'b0110: e.res = op.a - op.b;
      4'b0111: e.res = ($signed(op.a) < $signed(op.b)) ? 32'd1 : 32'd0;
      default: begin
        e.res = '0;
        e.err = 1'b1;
      end
    endcase
    e.zero = !e.err && (e.res == '0);
    return e;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    case ($urandom_range(0, 5))
      0:       o.ctrl = 4'b0000;
      1:       o.ctrl = 4'b0001;
      2:       o.ctrl = 4'b0010;
      3:       o.ctrl = 4'b0110;
      4:       o.ctrl = 4'b0111;
      default: o.ctrl = 4'($urandom);
    endcase
    if ($urandom_range(0, 3) == 0) begin
      o.a = DW'($urandom_range(0, 3));
      o.b = DW'($urandom_range(0, 3));
    end else begin
      o.a = $urandom;
      o.b = $urandom;
    end
    return o;
  endfunction

  // One cycle: drive at the falling edge, predict the grant, check readies
  // and ALU drive, and queue the expected response of a grant.
  task automatic step(input logic v0, input op_t o0, input logic v1, input op_t o1,
                      input logic rdy, output int win);
    op_t  sel;
    exp_t e;
    @(negedge clk_i);
    bus.req0_valid_i = v0;
    bus.req0_src1_i  = o0.a;
    bus.req0_src2_i  = o0.b;
    bus.req0_ctrl_i  = o0.ctrl;
    bus.req1_valid_i = v1;
    bus.req1_src1_i  = o1.a;
    bus.req1_src2_i  = o1.b;
    bus.req1_ctrl_i  = o1.ctrl;
    bus.rsp_ready_i  = rdy;
    win = -1;
    if (!m_busy) begin
      if (v0 && v1)  win = m_prio ? 1 : 0;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
    end
    #1;
    chk("req0_ready", 64'(bus.req0_ready_o), 64'(win == 0));
    chk("req1_ready", 64'(bus.req1_ready_o), 64'(win == 1));
    sel = (win == 0) ? o0 : (win == 1) ? o1 : mk_op(4'b0010, '0, '0);
    e   = ref_rsp(1'b0, sel, 0);
    chk("alu_src1", 64'(bus.alu_src1_o), 64'(sel.a));
    chk("alu_src2", 64'(bus.alu_src2_o), 64'(sel.b));
    chk("alu_ctrl", 64'(bus.alu_ctrl_o), 64'(e.err ? 4'b0010 : sel.ctrl));
    if (win >= 0) begin
      m_cnt++;
      sb_q.push_back(ref_rsp(win[0], sel, m_cnt));
      m_prio = (win == 0);
      m_busy = 1'b1;
    end else if (m_busy && rdy) begin
      m_busy = 1'b0;
    end
  endtask

  // Monitor: pop on each new response, then check it holds until retired.
  initial begin
    exp_t cur;
    logic have;
    logic prev_v;
    have   = 1'b0;
    prev_v = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_i) begin
        have   = 1'b0;
        prev_v = 1'b0;
      end else begin
        if (prev_v && bus.rsp_ready_i) have = 1'b0;
        if (bus.rsp_valid_o) begin
          if (!have) begin
            if (sb_q.size() == 0) begin
              chk("rsp_unexpected", 64'(bus.rsp_valid_o), 64'd0);
            end else begin
              cur  = sb_q.pop_front();
              have = 1'b1;
            end
          end
          if (have) begin
            chk("rsp_id",     64'(bus.rsp_id_o),     64'(cur.id));
            chk("rsp_result", 64'(bus.rsp_result_o), 64'(cur.res));
            chk("rsp_zero",   64'(bus.rsp_zero_o),   64'(cur.zero));
            chk("rsp_err",    64'(bus.rsp_err_o),    64'(cur.err));
            chk("ops_cnt",    64'(bus.ops_cnt_o),    64'(cur.cnt));
          end
        end
        prev_v = bus.rsp_valid_o;
      end
    end
  end

  initial begin
    op_t  idle, o0, o1;
    logic v0, v1;
    int   w, last_grant;
    idle = mk_op(4'b0010, '0, '0);
    bus.req0_valid_i = 1'b0; bus.req0_src1_i = '0; bus.req0_src2_i = '0; bus.req0_ctrl_i = '0;
    bus.req1_valid_i = 1'b0; bus.req1_src1_i = '0; bus.req1_src2_i = '0; bus.req1_ctrl_i = '0;
    bus.rsp_ready_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("reset_valid",  64'(bus.rsp_valid_o),  64'd0);
    chk("reset_id",     64'(bus.rsp_id_o),     64'd0);
    chk("reset_result", 64'(bus.rsp_result_o), 64'd0);
    chk("reset_zero",   64'(bus.rsp_zero_o),   64'd0);
    chk("reset_err",    64'(bus.rsp_err_o),    64'd0);
    chk("reset_cnt",    64'(bus.ops_cnt_o),    64'd0);

    // Single request, then reset while the response is pending.
    step(1'b1, mk_op(4'b0010, 32'd5, 32'd7), 1'b0, idle, 1'b0, w);
    @(posedge clk_i); #1;
    chk("single_valid",  64'(bus.rsp_valid_o),  64'd1);
    chk("single_result", 64'(bus.rsp_result_o), 64'd12);
    chk("single_cnt",    64'(bus.ops_cnt_o),    64'd1);
    step(1'b0, idle, 1'b0, idle, 1'b0, w);
    #2;
    bus.req0_valid_i = 1'b1;
    rst_i = 1'b0;
    #1;
    chk("rst_mid_valid",  64'(bus.rsp_valid_o),  64'd0);
    chk("rst_mid_result", 64'(bus.rsp_result_o), 64'd0);
    chk("rst_mid_cnt",    64'(bus.ops_cnt_o),    64'd0);
    chk("rst_mid_ready0", 64'(bus.req0_ready_o), 64'd0);
    sb_q.delete();
    m_busy = 1'b0; m_prio = 1'b0; m_cnt = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.req0_valid_i = 1'b0;
    rst_i = 1'b1;

    // Directed operations, each retired before the next.
    step(1'b1, mk_op(4'b0010, 32'd1, 32'd1), 1'b0, idle, 1'b0, w);
    @(posedge clk_i); #1;
    chk("post_rst_add", 64'(bus.rsp_result_o), 64'd2);
    step(1'b0, idle, 1'b0, idle, 1'b1, w);
    step(1'b0, idle, 1'b1, mk_op(4'b0110, 32'd9, 32'd9), 1'b0, w);
    @(posedge clk_i); #1;
    chk("sub_zero", 64'(bus.rsp_zero_o), 64'd1);
    step(1'b0, idle, 1'b0, idle, 1'b1, w);
    step(1'b1, mk_op(4'b0111, 32'hFFFF_FFFF, 32'd1), 1'b0, idle, 1'b1, w);
    step(1'b0, idle, 1'b0, idle, 1'b1, w);
    step(1'b1, mk_op(4'b1111, 32'd3, 32'd4), 1'b0, idle, 1'b0, w);
    @(posedge clk_i); #1;
    chk("illegal_err", 64'(bus.rsp_err_o), 64'd1);
    step(1'b0, idle, 1'b0, idle, 1'b1, w);

    // Backpressure: req1 waits through three stalled cycles and the retirement.
    o1 = mk_op(4'b0001, 32'h00F0, 32'h0F00);
    step(1'b1, mk_op(4'b0000, 32'hFF, 32'h3C), 1'b0, idle, 1'b0, w);
    repeat (3) step(1'b0, idle, 1'b1, o1, 1'b0, w);
    step(1'b0, idle, 1'b1, o1, 1'b1, w);
    step(1'b0, idle, 1'b1, o1, 1'b0, w);
    chk("bp_grant_req1", 64'(w), 64'd1);
    step(1'b0, idle, 1'b0, idle, 1'b1, w);

    // Round-robin: both requesters continuously valid.
    o0 = mk_op(4'b0010, 32'd100, 32'd1);
    last_grant = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, o0, 1'b1, o1, 1'b1, w);
      if (w >= 0) begin
        if (last_grant >= 0) chk("rr_alternate", 64'(w), 64'(1 - last_grant));
        last_grant = w;
      end
    end
    step(1'b0, idle, 1'b0, idle, 1'b1, w);

    // Randomized traffic; a pending request holds its operation or drops out.
    v0 = 1'b0; v1 = 1'b0; o0 = idle; o1 = idle; w = -1;
    for (int i = 0; i < 2500; i++) begin
      if (!(v0 && w != 0 && $urandom_range(0, 9) != 0)) begin
        v0 = ($urandom_range(0, 99) < 60);
        o0 = rand_op();
      end
      if (!(v1 && w != 1 && $urandom_range(0, 9) != 0)) begin
        v1 = ($urandom_range(0, 99) < 60);
        o1 = rand_op();
      end
      step(v0, o0, v1, o1, logic'($urandom_range(0, 3) != 0), w);
    end
    repeat (2) step(1'b0, idle, 1'b0, idle, 1'b1, w);

    // Counter wrap.
    while ((m_cnt % (1 << CNTW)) != (1 << CNTW) - 1) begin
      if (m_busy) step(1'b0, idle, 1'b0, idle, 1'b1, w);
      else        step(1'b1, rand_op(), 1'b0, idle, 1'b1, w);
    end
    if (m_busy) step(1'b0, idle, 1'b0, idle, 1'b1, w);
    step(1'b1, mk_op(4'b0010, 32'd2, 32'd3), 1'b0, idle, 1'b0, w);
    @(posedge clk_i); #1;
    chk("cnt_wrap", 64'(bus.ops_cnt_o), 64'd0);
    repeat (2) step(1'b0, idle, 1'b0, idle, 1'b1, w);

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
